// File: rtl/drop_game_pkg.sv
// Shared types and constants for the falling-object game controller:
// game states, screen geometry, LFSR seed and the LFSR-to-parameter mappings.
package drop_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  localparam int          SCREEN_W  = 640;
  localparam int          OBJ_W     = 20;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam logic [2:0] SHAPE_0 = 3'd0;
  localparam logic [2:0] SHAPE_1 = 3'd1;
  localparam logic [2:0] SHAPE_2 = 3'd2;

  // Out-of-range raw positions fold back by 512, which always lands on-screen.
  function automatic logic [9:0] lfsr_pos_x(input logic [15:0] v);
    logic [9:0] raw;
    raw = v[9:0];
    return (int'(raw) >= SCREEN_W - OBJ_W) ? raw - 10'd512 : raw;
  endfunction

  function automatic logic [2:0] lfsr_shape(input logic [15:0] v);
    return (v[11:10] == 2'd3) ? SHAPE_0 : {1'b0, v[11:10]};
  endfunction

  function automatic logic [2:0] lfsr_color(input logic [15:0] v);
    return (v[14:12] == 3'd0) ? 3'b111 : v[14:12];
  endfunction

endpackage

// File: rtl/drop_spawner_if.sv
// Falling-object slot bus: per-slot control/parameters out, point/bottom flags back.
// master = game controller, slave = slot array.
interface drop_spawner_if #(
  parameter int N_SLOTS = 4
);
  logic [N_SLOTS-1:0]    slot_point;
  logic [N_SLOTS-1:0]    slot_bottom;
  logic [N_SLOTS-1:0]    slot_clr;
  logic [N_SLOTS-1:0]    slot_en;
  logic [10*N_SLOTS-1:0] slot_pos_x;
  logic [3*N_SLOTS-1:0]  slot_color;
  logic [3*N_SLOTS-1:0]  slot_shape;
  logic [10*N_SLOTS-1:0] slot_speed;
  logic [10*N_SLOTS-1:0] slot_delay;

  modport master (
    input  slot_point, slot_bottom,
    output slot_clr, slot_en, slot_pos_x, slot_color, slot_shape, slot_speed, slot_delay
  );

  modport slave (
    output slot_point, slot_bottom,
    input  slot_clr, slot_en, slot_pos_x, slot_color, slot_shape, slot_speed, slot_delay
  );
endinterface

// File: rtl/drop_lfsr.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11, shifting right.
// i_load has priority and reloads SEED synchronously.
module drop_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        i_load,
  input  logic        i_en,
  output logic [15:0] o_lfsr
);
  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign o_lfsr = r_lfsr;

  always_ff @(posedge clk) begin
    if (i_load)    r_lfsr <= SEED;
    else if (i_en) r_lfsr <= {w_fb, r_lfsr[15:1]};
  end
endmodule

// File: rtl/drop_spawner.sv
// Game controller: allocates falling-object slots, keeps score/lives, runs IDLE/PLAY/OVER.
// Define DROP_SPEED_RAMP_EN to make newly spawned objects faster as the score grows.
module drop_spawner
  import drop_game_pkg::*;
#(
  parameter int N_SLOTS     = 4,
  parameter int SPAWN_TICKS = 60,
  parameter int MAX_LIVES   = 3,
  parameter int SPEED_START = 4,
  parameter int SCORE_MAX   = 999
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           tick,
  drop_spawner_if.master slot_bus,
  output logic [9:0]     score,
  output logic [1:0]     lives,
  output logic [1:0]     game_state
);
  localparam int TMR_W = $clog2(SPAWN_TICKS + 1);
  localparam int CNT_W = $clog2(N_SLOTS + 1);
  localparam logic [TMR_W-1:0] TMR_SAT = TMR_W'(SPAWN_TICKS);

  game_state_t        r_state, w_state_next;
  logic [9:0]         r_score, w_score_next;
  logic [1:0]         r_lives, w_lives_next;
  logic [TMR_W-1:0]   r_timer, w_timer_next;
  logic [N_SLOTS-1:0] r_busy, w_busy_next, r_scored, w_scored_next;
  logic [N_SLOTS-1:0] r_en, r_clr, w_hits, w_misses, w_alloc_oh;
  logic [CNT_W-1:0]   w_n_hits, w_n_misses;
  logic               w_alloc;
  logic [15:0]        w_lfsr;
  logic [9:0]         w_new_speed;
  logic [9:0]         r_pos_x [N_SLOTS];
  logic [9:0]         r_speed [N_SLOTS];
  logic [2:0]         r_color [N_SLOTS];
  logic [2:0]         r_shape [N_SLOTS];

  drop_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .i_load (reset),
    .i_en   (1'b1),
    .o_lfsr (w_lfsr)
  );

  // A point arriving with bottom in the same cycle wins: it is a hit, never a miss.
  assign w_hits   = r_busy & slot_bus.slot_point & ~r_scored;
  assign w_misses = r_busy & slot_bus.slot_bottom & ~r_scored & ~slot_bus.slot_point;

  always_comb begin
    w_n_hits   = '0;
    w_n_misses = '0;
    w_alloc_oh = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_n_hits   = w_n_hits + CNT_W'(w_hits[i]);
      w_n_misses = w_n_misses + CNT_W'(w_misses[i]);
    end
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_alloc_oh    = '0;
        w_alloc_oh[i] = 1'b1;
      end
    end
  end

`ifdef DROP_SPEED_RAMP_EN
  logic [9:0] w_ramp;
  assign w_ramp      = r_score >> 3;
  assign w_new_speed = (10'(SPEED_START) > w_ramp + 10'd1) ? 10'(SPEED_START) - w_ramp : 10'd1;
`else
  assign w_new_speed = 10'(SPEED_START);
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_score_next = r_score;
    w_lives_next = r_lives;
    w_timer_next = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_PLAY;
          w_score_next = '0;
          w_lives_next = 2'(MAX_LIVES);
        end
      end
      ST_PLAY: begin
        w_score_next = (int'(r_score) + int'(w_n_hits) > SCORE_MAX) ? 10'(SCORE_MAX)
                                                                   : r_score + 10'(w_n_hits);
        w_lives_next = (int'(w_n_misses) >= int'(r_lives)) ? 2'd0 : r_lives - 2'(w_n_misses);
        if (w_lives_next == 2'd0)  w_state_next = ST_OVER;
        else if (r_timer == TMR_SAT) w_timer_next = (|w_alloc_oh) ? '0 : r_timer;
        else if (tick)             w_timer_next = r_timer + 1'b1;
      end
      ST_OVER: begin
        if (start) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_alloc = (r_state == ST_PLAY) && (w_state_next == ST_PLAY) &&
                   (r_timer == TMR_SAT) && (|w_alloc_oh);

  always_comb begin
    w_busy_next   = r_busy & ~slot_bus.slot_bottom;
    w_scored_next = r_scored | w_hits;
    if (w_alloc) begin
      w_busy_next   = w_busy_next | w_alloc_oh;
      w_scored_next = w_scored_next & ~w_alloc_oh;
    end
    if (w_state_next != ST_PLAY) begin
      w_busy_next   = '0;
      w_scored_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_score  <= '0;
      r_lives  <= 2'(MAX_LIVES);
      r_timer  <= '0;
      r_busy   <= '0;
      r_scored <= '0;
      r_en     <= '0;
      r_clr    <= '1;
    end else begin
      r_score  <= w_score_next;
      r_lives  <= w_lives_next;
      r_timer  <= w_timer_next;
      r_busy   <= w_busy_next;
      r_scored <= w_scored_next;
      r_en     <= w_busy_next;
      r_clr    <= ~w_busy_next;
    end
  end

  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pos_x[gi] <= '0;
          r_color[gi] <= '0;
          r_shape[gi] <= '0;
          r_speed[gi] <= 10'(SPEED_START);
        end else if (w_alloc && w_alloc_oh[gi]) begin
          r_pos_x[gi] <= lfsr_pos_x(w_lfsr);
          r_color[gi] <= lfsr_color(w_lfsr);
          r_shape[gi] <= lfsr_shape(w_lfsr);
          r_speed[gi] <= w_new_speed;
        end
      end
      assign slot_bus.slot_pos_x[10*gi +: 10] = r_pos_x[gi];
      assign slot_bus.slot_speed[10*gi +: 10] = r_speed[gi];
      assign slot_bus.slot_delay[10*gi +: 10] = 10'd0;
      assign slot_bus.slot_color[3*gi +: 3]   = r_color[gi];
      assign slot_bus.slot_shape[3*gi +: 3]   = r_shape[gi];
    end
  endgenerate

  assign slot_bus.slot_en  = r_en;
  assign slot_bus.slot_clr = r_clr;
  assign score             = r_score;
  assign lives             = r_lives;
  assign game_state        = r_state;
endmodule
